dmem_bus_bridge: RTL and testbench
==================================

// Module: dmem_bus_bridge
// PURPOSE
// Load/store port between the single-cycle datapath and a valid/ready data-memory bus.
// Takes the datapath's address, store data and access size, and issues one bus transaction.
// Stalls the CPU until the transaction completes, then returns the load word lane-aligned to bit 0.
// load_extend then applies sign or zero extension to that word.
// PARAMETERS
// TIMEOUT   255  max cycles spent waiting in REQ or RESP before abort; 8-bit counter, 1..255
// PORTS
// clk          in   1   system clock, rising edge
// reset        in   1   synchronous, active-low reset
// cpu_req      in   1   access request: load or store this instruction
// cpu_we       in   1   1 = store, 0 = load
// cpu_addr     in   32  byte address (datapath ALU result)
// cpu_wdata    in   32  store data; low byte/half/word significant
// cpu_size     in   2   00 byte, 01 half, 10 word, 11 treated as word
// cpu_rdata    out  32  load word, shifted right by 8*addr[1:0]; valid in DONE
// cpu_stall    out  1   holds PC and regfile write while high
// bus_valid    out  1   request valid
// bus_ready    in   1   request accepted
// bus_we       out  1   write request
// bus_addr     out  32  {addr[31:2],2'b00}
// bus_wdata    out  32  lane-replicated store data
// bus_wstrb    out  4   byte enables; 4'b0000 on reads
// bus_rvalid   in   1   read data valid
// bus_rdata    in   32  read word
// bus_err      out  1   one-cycle pulse on timeout (or misalign, see CONFIGURATION)
// BEHAVIOUR
// - Reset values: state=IDLE, bus_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0.
//   Also cpu_rdata=0, bus_err=0, timeout counter=0.
// - Reset takes effect at the next clk edge.
// - If reset asserts mid-transaction, bus_valid is low the cycle after.
// - rvalid arriving in IDLE is ignored.
// - cpu_stall = cpu_req & (state != DONE), combinational.
// - FSM transitions:
//   IDLE -> REQ on cpu_req; latch we, addr, size, formatted wdata and wstrb.
//   REQ: bus_valid=1, outputs held stable until bus_ready.
//     On handshake, a write goes to DONE and a read goes to RESP.
//   RESP: wait for bus_rvalid (earliest is the cycle after handshake).
//     On rvalid, cpu_rdata <= bus_rdata >> 8*addr[1:0]; go to DONE.
//   DONE: stall low for exactly one cycle, so the CPU commits; then go to IDLE.
// - Minimum stall: 2 cycles for a store, 3 for a load (zero-wait bus).
// - Back-to-back: a new cpu_req seen in IDLE right after DONE starts a fresh transaction.
// - wstrb:
//   byte = 4'b0001 << addr[1:0]
//   half = 4'b0011 << {addr[1],1'b0}
//   word = 4'b1111
// - wdata:
//   byte = {4{wdata[7:0]}}
//   half = {2{wdata[15:0]}}
//   word = wdata
// - Timeout: the counter clears on entry to REQ and on entry to RESP, and increments each waiting cycle.
//   When it reaches TIMEOUT: drop bus_valid, pulse bus_err, set cpu_rdata=0, go to DONE.
// - A late bus_rvalid after a timeout is ignored.
// CONFIGURATION
// DMEM_MISALIGN_TRAP_EN defined: misalign detection is enabled.
// - A misaligned access is a half with addr[0]=1, or a word with addr[1:0]!=0.
// - No bus transaction is issued; IDLE -> DONE directly (stall 1 cycle).
// - bus_err pulses in DONE and cpu_rdata=0.
// DMEM_MISALIGN_TRAP_EN undefined: no check.
// - Misaligned low address bits are forced to size alignment (half: addr[0]=0, word: addr[1:0]=0) before strobe/shift.
// - bus_err reports timeout only.
// TESTING
// 1. sw, addr 0x0000_1004, wdata 0xCAFE_BABE, bus_ready=1 -> bus_wstrb=1111, bus_addr=0x1004, stall 2 cycles.
// 2. sb, addr 0x0000_2003, wdata 0x0000_00A5 -> bus_wstrb=1000, bus_wdata=0xA5A5_A5A5.
// 3. lh, addr 0x0000_3002, bus_rdata=0x8001_1234, rvalid 2 cycles after handshake -> cpu_rdata=0x0000_8001 in DONE, stall 4 cycles.
// 4. lw, bus_ready held 0 -> after 255 REQ cycles bus_valid drops, bus_err=1 for 1 cycle, cpu_rdata=0, stall releases.
// 5. reset low while in RESP -> next cycle IDLE, bus_valid=0; a subsequent rvalid=1 causes no cpu_rdata change.
// 6. With DMEM_MISALIGN_TRAP_EN: sw addr 0x0000_1002 -> bus_valid never asserts, bus_err pulses, stall 1 cycle.
//    Without it: the same access writes bus_addr=0x1000 with wstrb=1111.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// Load/store bridge from the single-cycle datapath to a valid/ready data-memory bus; stalls the CPU until done.
// Optional misalign trap enabled by defining DMEM_MISALIGN_TRAP_EN (default: low address bits forced to size alignment).
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [1:0]  i_cpu_size,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_off;
  logic [31:0] r_cpu_rdata;
  logic        r_bus_valid;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;
  logic        r_bus_err;

  logic        w_is_byte;
  logic        w_is_half;
  logic [1:0]  w_off;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_trap;
  logic [7:0]  w_cnt_inc;
  logic        w_cnt_expired;

  assign w_is_byte = (i_cpu_size == 2'b00);
  assign w_is_half = (i_cpu_size == 2'b01);

  // Size 11 falls through to word handling everywhere below.
  always_comb begin
    w_off   = 2'b00;
    w_wstrb = 4'b1111;
    w_wdata = i_cpu_wdata;
    if (w_is_byte) begin
      w_off   = i_cpu_addr[1:0];
      w_wstrb = 4'b0001 << i_cpu_addr[1:0];
      w_wdata = {4{i_cpu_wdata[7:0]}};
    end else if (w_is_half) begin
      w_off   = {i_cpu_addr[1], 1'b0};
      w_wstrb = 4'b0011 << {i_cpu_addr[1], 1'b0};
      w_wdata = {2{i_cpu_wdata[15:0]}};
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap = (w_is_half & i_cpu_addr[0]) |
                  (i_cpu_size[1] & (i_cpu_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  assign w_cnt_inc     = r_cnt + 8'd1;
  assign w_cnt_expired = (w_cnt_inc == LP_TIMEOUT);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_off       <= 2'b00;
      r_cpu_rdata <= 32'd0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_wstrb <= 4'b0000;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req) begin
            if (w_trap) begin
              r_state     <= S_DONE;
              r_bus_err   <= 1'b1;
              r_cpu_rdata <= 32'd0;
            end else begin
              r_state     <= S_REQ;
              r_cnt       <= 8'd0;
              r_off       <= w_off;
              r_bus_valid <= 1'b1;
              r_bus_we    <= i_cpu_we;
              r_bus_addr  <= {i_cpu_addr[31:2], 2'b00};
              r_bus_wdata <= w_wdata;
              r_bus_wstrb <= i_cpu_we ? w_wstrb : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (i_bus_ready) begin
            r_bus_valid <= 1'b0;
            r_cnt       <= 8'd0;
            r_state     <= r_bus_we ? S_DONE : S_RESP;
          end else if (w_cnt_expired) begin
            r_bus_valid <= 1'b0;
            r_bus_err   <= 1'b1;
            r_cpu_rdata <= 32'd0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          if (i_bus_rvalid) begin
            r_cpu_rdata <= i_bus_rdata >> {r_off, 3'b000};
            r_state     <= S_DONE;
          end else if (w_cnt_expired) begin
            r_bus_err   <= 1'b1;
            r_cpu_rdata <= 32'd0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          // One unstalled cycle lets the CPU commit before the next access.
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_stall = i_cpu_req & (r_state != S_DONE);
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_bus_valid = r_bus_valid;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_wstrb = r_bus_wstrb;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: directed loads/stores, timeout, misalign and mid-transaction reset.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.TIMEOUT(255)) dut (
    .i_clk(clk), .i_reset(reset_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_size(cpu_size),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .o_bus_valid(bus_valid), .i_bus_ready(bus_ready), .o_bus_we(bus_we),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_wstrb(bus_wstrb),
    .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata), .o_bus_err(bus_err)
  );

  typedef struct {
    logic        ebus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          stall;
    int          vcyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus responder: returns read data g_rdly cycles after a read handshake.
  int          g_rdly     = 1;
  logic [31:0] g_rdata    = 32'd0;
  logic        g_force_rv = 1'b0;
  logic        g_sb_en    = 1'b1;
  int          pend       = 0;

  initial begin
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
  end

  always @(negedge clk) begin
    bus_rdata = g_rdata;
    if (bus_valid && bus_ready && !bus_we) begin
      pend       = g_rdly;
      bus_rvalid = 1'b0;
    end else if (pend > 0) begin
      pend--;
      bus_rvalid = (pend == 0);
    end else begin
      bus_rvalid = 1'b0;
    end
    if (g_force_rv) bus_rvalid = 1'b1;
  end

  // Monitor: checks bus requests at handshake and the CPU result on the unstalled cycle.
  int stall_cnt = 0;
  int vcyc_cnt  = 0;

  always @(negedge clk) begin
    if (cpu_req && cpu_stall) stall_cnt++;
    if (bus_valid) vcyc_cnt++;
    if (bus_err) chk("err_only_in_done", {31'd0, cpu_req && !cpu_stall}, 32'd1);
    if (g_sb_en && bus_valid && bus_ready) begin
      if (q.size() == 0 || !q[0].ebus) begin
        chk("unexpected_bus_req", 32'd1, 32'd0);
      end else begin
        chk("bus_addr", bus_addr, q[0].addr);
        chk("bus_we", {31'd0, bus_we}, {31'd0, q[0].we});
        chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, q[0].wstrb});
        if (q[0].we) chk("bus_wdata", bus_wdata, q[0].wdata);
      end
    end
    if (cpu_req && !cpu_stall) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("stall_cycles", stall_cnt, e.stall);
        chk("valid_cycles", vcyc_cnt, e.vcyc);
        chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        chk("bus_valid_in_done", {31'd0, bus_valid}, 32'd0);
        if (!e.we || e.err) chk("cpu_rdata", cpu_rdata, e.rdata);
      end
      stall_cnt = 0;
      vcyc_cnt  = 0;
    end
    if (!cpu_req) begin
      stall_cnt = 0;
      vcyc_cnt  = 0;
    end
  end

  task automatic txn(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic rdy, input int rdly,
                     input logic [31:0] rdat, input logic ebus, input logic [31:0] eaddr,
                     input logic [31:0] ewdata, input logic [3:0] estrb,
                     input logic [31:0] erdata, input logic eerr, input int estall,
                     input int evcyc, input logic keep);
    exp_t e;
    logic done;
    e.ebus = ebus; e.we = we; e.addr = eaddr; e.wdata = ewdata; e.wstrb = estrb;
    e.rdata = erdata; e.err = eerr; e.stall = estall; e.vcyc = evcyc;
    q.push_back(e);
    bus_ready = rdy;
    g_rdly    = rdly;
    g_rdata   = rdat;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_size  = sz;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (cpu_req && !cpu_stall) done = 1'b1;
    end
    chk("txn_completes", {31'd0, done}, 32'd1);
    if (!done) begin
      q.delete();
      reset_n = 1'b0;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
    @(posedge clk); #1;
    if (!keep) cpu_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
    cpu_wdata = 32'd0; cpu_size = 2'b00; bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // we sz addr wdata rdy rdly rdat | ebus eaddr ewdata estrb erdata eerr estall evcyc keep
    txn(1, 2'b10, 32'h0000_1004, 32'hCAFE_BABE, 1, 1, 32'h0,
        1, 32'h0000_1004, 32'hCAFE_BABE, 4'b1111, 32'h0, 0, 2, 1, 0);
    txn(1, 2'b00, 32'h0000_2003, 32'h0000_00A5, 1, 1, 32'h0,
        1, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000, 32'h0, 0, 2, 1, 0);
    txn(0, 2'b01, 32'h0000_3002, 32'h0, 1, 2, 32'h8001_1234,
        1, 32'h0000_3000, 32'h0, 4'b0000, 32'h0000_8001, 0, 4, 1, 0);
    txn(0, 2'b00, 32'h0000_4001, 32'h0, 1, 1, 32'h1122_3344,
        1, 32'h0000_4000, 32'h0, 4'b0000, 32'h0011_2233, 0, 3, 1, 0);
    txn(1, 2'b01, 32'h0000_5002, 32'h0000_BEEF, 1, 1, 32'h0,
        1, 32'h0000_5000, 32'hBEEF_BEEF, 4'b1100, 32'h0, 0, 2, 1, 0);
    txn(0, 2'b10, 32'h0000_6000, 32'h0, 1, 1, 32'hDEAD_BEEF,
        1, 32'h0000_6000, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0, 3, 1, 0);
    txn(1, 2'b11, 32'h0000_7008, 32'h1234_5678, 1, 1, 32'h0,
        1, 32'h0000_7008, 32'h1234_5678, 4'b1111, 32'h0, 0, 2, 1, 0);
    txn(1, 2'b00, 32'h0000_8000, 32'h1234_5677, 1, 1, 32'h0,
        1, 32'h0000_8000, 32'h7777_7777, 4'b0001, 32'h0, 0, 2, 1, 0);
    // Back-to-back: request stays high straight into the next access.
    txn(0, 2'b10, 32'h0000_0100, 32'h0, 1, 1, 32'h0102_0304,
        1, 32'h0000_0100, 32'h0, 4'b0000, 32'h0102_0304, 0, 3, 1, 1);
    txn(1, 2'b00, 32'h0000_0101, 32'h0000_005A, 1, 1, 32'h0,
        1, 32'h0000_0100, 32'h5A5A_5A5A, 4'b0010, 32'h0, 0, 2, 1, 0);
    // Bus never ready: 255 REQ cycles then abort.
    txn(0, 2'b10, 32'h0000_9000, 32'h0, 0, 1, 32'h0,
        1, 32'h0000_9000, 32'h0, 4'b0000, 32'h0, 1, 256, 255, 0);
    repeat (2) @(posedge clk); #1;
`ifdef DMEM_MISALIGN_TRAP_EN
    txn(1, 2'b10, 32'h0000_1002, 32'h1357_9BDF, 1, 1, 32'h0,
        0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 1, 0, 0);
    txn(0, 2'b01, 32'h0000_3003, 32'h0, 1, 1, 32'hAABB_CCDD,
        0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 1, 0, 0);
`else
    txn(1, 2'b10, 32'h0000_1002, 32'h1357_9BDF, 1, 1, 32'h0,
        1, 32'h0000_1000, 32'h1357_9BDF, 4'b1111, 32'h0, 0, 2, 1, 0);
    txn(0, 2'b01, 32'h0000_3003, 32'h0, 1, 1, 32'hAABB_CCDD,
        1, 32'h0000_3000, 32'h0, 4'b0000, 32'h0000_AABB, 0, 3, 1, 0);
`endif
    txn(0, 2'b10, 32'h0000_B000, 32'h0, 1, 1, 32'h55AA_55AA,
        1, 32'h0000_B000, 32'h0, 4'b0000, 32'h55AA_55AA, 0, 3, 1, 0);

    // Reset while waiting in RESP, then a stray rvalid in IDLE.
    g_sb_en   = 1'b0;
    bus_ready = 1'b1;
    g_rdly    = 20;
    g_rdata   = 32'h0;
    cpu_req   = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0000_A000;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, bus_valid}, 32'd0);
    chk("midrst_rdata", cpu_rdata, 32'd0);
    chk("midrst_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    g_rdata    = 32'hFFFF_FFFF;
    g_force_rv = 1'b1;
    repeat (2) @(posedge clk); #1;
    g_force_rv = 1'b0;
    @(negedge clk);
    chk("idle_rvalid_ignored", cpu_rdata, 32'd0);
    chk("idle_rvalid_no_valid", {31'd0, bus_valid}, 32'd0);
    repeat (25) @(posedge clk); #1;
    g_sb_en = 1'b1;

    txn(0, 2'b00, 32'h0000_C003, 32'h0, 1, 1, 32'h9988_7766,
        1, 32'h0000_C000, 32'h0, 4'b0000, 32'h0000_0099, 0, 3, 1, 0);
    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
